// File: rtl/sr_icache_if.sv
// Fetch-side and refill-side buses of sr_icache.
// master is the core/memory side, slave is the cache.
interface sr_icache_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_drdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport master (
        output cpu_req, cpu_addr, mem_rdata, mem_rvalid,
        input  cpu_rdata, cpu_drdy, mem_req, mem_addr
    );

    modport slave (
        input  cpu_req, cpu_addr, mem_rdata, mem_rvalid,
        output cpu_rdata, cpu_drdy, mem_req, mem_addr
    );
endinterface

// File: rtl/sr_icache.sv
// Direct-mapped read-only instruction cache for the schoolRISCV fetch port.
// Single-cycle hits, in-order whole-line refill, bulk invalidate, hit/miss counters.
module sr_icache #(
    parameter  int unsigned INDEX_W  = 4,
    parameter  int unsigned OFFSET_W = 2,
    localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_icache_if.slave  bus,
    input  logic        inv,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned WORDS = 1 << OFFSET_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tagArr  [LINES];
    logic [31:0]         dataArr [LINES][WORDS];

    logic [31:0]         addrQ;
    logic                hitQ;
    logic [OFFSET_W-1:0] cnt;
    logic [OFFSET_W-1:0] cntNext;
    logic                invPend;

    logic [TAG_W-1:0]    tagQ;
    logic [INDEX_W-1:0]  idxQ;
    logic [OFFSET_W-1:0] offQ;
    logic [TAG_W-1:0]    reqTag;
    logic [INDEX_W-1:0]  reqIdx;
    logic [OFFSET_W-1:0] reqOff;

    logic                ready;
    logic                clearNow;
    logic                reqHit;

    assign {tagQ, idxQ, offQ}       = addrQ;
    assign {reqTag, reqIdx, reqOff} = bus.cpu_addr;
    assign cntNext                  = cnt + OFFSET_W'(1);

    assign ready    = (state == IDLE) || bus.cpu_drdy;
    assign clearNow = ready && (inv || invPend);
    // Tag compare is done at the accept edge so cpu_drdy is already registered in
    // the LOOKUP cycle; a request accepted alongside a clear must see an empty array.
    assign reqHit   = !clearNow && valid[reqIdx] && (tagArr[reqIdx] == reqTag);

    always_ff @(posedge clk) begin
        if (state == REFILL && bus.mem_rvalid) begin
            dataArr[idxQ][cnt] <= bus.mem_rdata;
            if (&cnt) begin
                tagArr[idxQ] <= tagQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            valid         <= '0;
            addrQ         <= '0;
            hitQ          <= 1'b0;
            cnt           <= '0;
            invPend       <= 1'b0;
            bus.cpu_drdy  <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            bus.cpu_drdy <= 1'b0;

            if (clearNow) begin
                valid   <= '0;
                invPend <= 1'b0;
            end else if (inv) begin
                invPend <= 1'b1;
            end

            case (state)
                LOOKUP: begin
                    if (hitQ) begin
                        hit_cnt <= hit_cnt + 32'd1;
                    end else begin
                        miss_cnt     <= miss_cnt + 32'd1;
                        cnt          <= '0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {tagQ, idxQ, {OFFSET_W{1'b0}}};
                        state        <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_rvalid) begin
                        cnt <= cntNext;
                        if (&cnt) begin
                            valid[idxQ]   <= 1'b1;
                            bus.mem_req   <= 1'b0;
                            bus.cpu_drdy  <= 1'b1;
                            // The last word is being written this edge; forward it.
                            bus.cpu_rdata <= (offQ == cnt) ? bus.mem_rdata : dataArr[idxQ][offQ];
                            state         <= RESP;
                        end else begin
                            bus.mem_addr <= {tagQ, idxQ, cntNext};
                        end
                    end
                end
                default: ;
            endcase

            if (ready) begin
                if (bus.cpu_req) begin
                    addrQ <= bus.cpu_addr;
                    hitQ  <= reqHit;
                    state <= LOOKUP;
                    if (reqHit) begin
                        bus.cpu_drdy  <= 1'b1;
                        bus.cpu_rdata <= dataArr[reqIdx][reqOff];
                    end
                end else begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_sr_icache.sv
// Directed bench for sr_icache: stimulus queues expected words, a negedge monitor
// pops them on every cpu_drdy; timing, counters and refill addresses are checked inline.
`timescale 1ns/1ps
module tb_sr_icache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inv;
    logic [31:0] hitCnt;
    logic [31:0] missCnt;

    sr_icache_if bus();

    sr_icache #(.INDEX_W(4), .OFFSET_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .inv      (inv),
        .hit_cnt  (hitCnt),
        .miss_cnt (missCnt)
    );

    always #5 clk = ~clk;

    int          nTests = 0;
    int          nFail  = 0;
    int          cyc    = 0;
    int          memLat = 2;
    int          waitCnt;
    int          reqCyc = 0;
    int          rvSeen;
    int          guard;
    int          drdySeen;
    logic [31:0] expQ[$];
    logic [31:0] chain[3];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Backing memory: rvalid in the memLat-th cycle an address is shown (1 = same cycle).
    assign bus.mem_rvalid = bus.mem_req && (waitCnt == memLat - 1);
    assign bus.mem_rdata  = bus.mem_rvalid ? memWord(bus.mem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              waitCnt <= 0;
        else if (!bus.mem_req || bus.mem_rvalid) waitCnt <= 0;
        else                                     waitCnt <= waitCnt + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.cpu_drdy === 1'b1) begin
            if (expQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL unexpected_drdy: got rdata %h, expected no response", bus.cpu_rdata);
            end else begin
                check("rdata", bus.cpu_rdata, expQ.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        expQ.push_back(memWord(a));
        reqCyc = cyc;
        step();
        bus.cpu_req = 1'b0;
    endtask

    task automatic waitResp(input string name, input int expLat);
        int n = 0;
        while (bus.cpu_drdy !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check(name, cyc - reqCyc, expLat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        inv          = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        chain[0]     = 32'h10;
        chain[1]     = 32'h11;
        chain[2]     = 32'h13;
        step(3);
        check("rst_drdy", bus.cpu_drdy, 0);
        check("rst_rdata", bus.cpu_rdata, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_hit_cnt", hitCnt, 0);
        check("rst_miss_cnt", missCnt, 0);
        rst_n = 1'b1;
        step();

        // Cold miss with latency 2
        memLat = 2;
        issue(32'h12);
        check("t1_lookup_drdy", bus.cpu_drdy, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t1_mem_req", bus.mem_req, 1);
            check("t1_mem_addr", bus.mem_addr, 32'h10 + k / 2);
            if (k == 0) check("t1_miss_cnt", missCnt, 1);
        end
        step();
        check("t1_drdy", bus.cpu_drdy, 1);
        check("t1_mem_req_low", bus.mem_req, 0);
        check("t1_latency", cyc - reqCyc, 10);
        step();

        // Back-to-back hits
        for (int i = 0; i < 3; i++) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = chain[i];
            expQ.push_back(memWord(chain[i]));
            step();
            check("t2_drdy", bus.cpu_drdy, 1);
            check("t2_mem_req", bus.mem_req, 0);
        end
        bus.cpu_req = 1'b0;
        step();
        check("t2_drdy_end", bus.cpu_drdy, 0);
        check("t2_hit_cnt", hitCnt, 3);

        // Conflict on index 4
        issue(32'h50);
        waitResp("t3_lat_50", 10);
        step();
        issue(32'h12);
        waitResp("t3_lat_12", 10);
        step();
        check("t3_miss_cnt", missCnt, 3);
        check("t3_hit_cnt", hitCnt, 3);

        // Invalidate during refill, re-request in the RESP cycle
        issue(32'h20);
        step(4);
        inv = 1'b1;
        step();
        inv = 1'b0;
        waitResp("t4_lat_20", 10);
        issue(32'h20);
        waitResp("t4_lat_20_again", 10);
        step();
        check("t4_miss_cnt", missCnt, 5);
        check("t4_hit_cnt", hitCnt, 3);

        // Reset after the 2nd refill word
        issue(32'h34);
        rvSeen = 0;
        guard  = 0;
        while (rvSeen < 2 && guard < 50) begin
            if (bus.mem_rvalid) rvSeen++;
            step();
            guard++;
        end
        check("t5_rvalid_seen", rvSeen, 2);
        rst_n = 1'b0;
        expQ.delete();
        #1;
        check("t5_mem_req", bus.mem_req, 0);
        check("t5_drdy", bus.cpu_drdy, 0);
        check("t5_hit_cnt", hitCnt, 0);
        check("t5_miss_cnt", missCnt, 0);
        step(2);
        rst_n = 1'b1;
        drdySeen = 0;
        repeat (15) begin
            step();
            if (bus.cpu_drdy) drdySeen++;
        end
        check("t5_no_drdy", drdySeen, 0);
        issue(32'h34);
        waitResp("t5_lat_after_reset", 10);
        step();
        check("t5_miss_after", missCnt, 1);
        check("t5_hit_after", hitCnt, 0);

        // Latency 1 and 5 on the same address
        memLat = 1;
        issue(32'h44);
        waitResp("t6_lat1", 6);
        step();
        inv = 1'b1;
        step();
        inv = 1'b0;
        memLat = 5;
        issue(32'h44);
        waitResp("t6_lat5", 22);
        step();
        check("t6_miss_cnt", missCnt, 3);
        check("t6_hit_cnt", hitCnt, 0);

        step(2);
        check("final_queue_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/sr_icache.md
Name: sr_icache

Overview:
- Direct-mapped, read-only instruction cache between the schoolRISCV core's instruction fetch port and the backing instruction memory.
- Accepts one word-address fetch request per transaction from the core. Returns the instruction with a one-cycle `cpu_drdy` pulse.
- On a miss, refills the whole line from memory one word at a time.
- Provides a whole-cache invalidate input and hit/miss performance counters.

Parameters:
- `INDEX_W`, 4, line index bits; the cache has 2^INDEX_W lines.
- `OFFSET_W`, 2, word-in-line bits; each line holds 2^OFFSET_W words.
- `TAG_W`, 32-INDEX_W-OFFSET_W, tag bits. This is derived; never override it.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `cpu_req` in 1: single-cycle fetch request.
- `cpu_addr` in 32: word address. Split as {tag, index, offset} from MSB to LSB.
- `cpu_rdata` out 32: instruction word.
- `cpu_drdy` out 1: one-cycle pulse; `cpu_rdata` is valid in that cycle.
- `inv` in 1: invalidate all lines.
- `mem_req` out 1: refill request, held high for the whole refill.
- `mem_addr` out 32: word address of the refill word currently requested.
- `mem_rdata` in 32: refill data.
- `mem_rvalid` in 1: `mem_rdata` is valid for the current `mem_addr`.
- `hit_cnt` out 32: lookup hits.
- `miss_cnt` out 32: lookup misses.

Behaviour:
- Storage:
  - `valid[2^INDEX_W]`: flops, reset to 0.
  - `tag` array and `data` array: flops, not reset, read combinationally.
- States: IDLE, LOOKUP, REFILL, RESP. Reset state is IDLE.
- Reset values: `cpu_drdy`=0, `cpu_rdata`=0, `mem_req`=0, `mem_addr`=0, both counters 0, word counter 0, pending-invalidate flag 0.
- Ready cycle: state IDLE, or any cycle with `cpu_drdy`=1.
  - `cpu_req` is sampled only in ready cycles. `cpu_req` in any other cycle is ignored; the core never issues one there.
  - When sampled, `cpu_addr` is latched into `addr_q` and the next state is LOOKUP.
  - The core issues its next request in the same cycle as `cpu_drdy`; back-to-back hits must give `cpu_drdy` on consecutive cycles.
- LOOKUP (one cycle), using `idx_q`/`tag_q`/`off_q` from `addr_q`:
  - Hit (`valid[idx_q]` and `tag[idx_q]`==`tag_q`): `cpu_drdy`=1, `cpu_rdata`=`data[idx_q][off_q]`, `hit_cnt`+1. Next state is LOOKUP if a new `cpu_req` is present, else IDLE.
  - Miss: `miss_cnt`+1, word counter `cnt`=0, next state REFILL.
  - Hit latency is 1 cycle after the request.
- REFILL:
  - `mem_req`=1 and `mem_addr`={`tag_q`, `idx_q`, `cnt`}.
  - On `mem_rvalid`: write `mem_rdata` to `data[idx_q][cnt]` and increment `cnt`; `mem_addr` advances on the next cycle.
  - On `mem_rvalid` with `cnt`==2^OFFSET_W-1: write `tag[idx_q]`=`tag_q`, set `valid[idx_q]`=1, go to RESP.
  - `mem_req` drops to 0 in the RESP cycle.
  - `mem_rvalid` outside REFILL is ignored.
  - The memory may take any latency ≥1 cycle per word, where 1 means same-cycle (combinational) return.
  - Words are always fetched in order, starting from offset 0, not critical-word-first.
- RESP (one cycle): `cpu_drdy`=1, `cpu_rdata`=`data[idx_q][off_q]`. This is a ready cycle, so it goes to LOOKUP on `cpu_req`, else IDLE.
- `cpu_rdata` when `cpu_drdy`=0 holds the last delivered word, via a register loaded on every `cpu_drdy`.
- Invalidate:
  - `inv`=1 sets `inv_pend`.
  - All valid bits are cleared at the first ready-cycle clock edge where `inv` or `inv_pend` is 1; `inv_pend` clears at that edge.
  - A request accepted in that same cycle sees the cleared array, so its lookup misses.
  - If the invalidate is pending during REFILL, the refill still completes and RESP still delivers the word. The line is then cleared at the RESP edge.
- Counters are 32-bit, wrap modulo 2^32, and count exactly once per LOOKUP.
- Asynchronous reset mid-refill: immediately returns to IDLE with `mem_req`=0 and all valid bits clear. No `cpu_drdy` is produced for the aborted request.

Test Plan:
1. Cold miss. Memory latency L=2 (`mem_rvalid` in the 2nd cycle each address is shown); `cpu_req` with `cpu_addr`=0x12 at cycle 0 -> `miss_cnt`=1; `mem_addr` = 0x10, 0x11, 0x12, 0x13 over cycles 2-9; `cpu_drdy` at cycle 10 with `cpu_rdata`=mem[0x12]; `mem_req` low at cycle 10.
2. Hit chain. After test 1, issue a request for 0x10 and then re-request 0x11, 0x13 on each `cpu_drdy` cycle -> `cpu_drdy` on 3 consecutive cycles with the correct words; `hit_cnt`=3; `mem_req` stays 0.
3. Conflict. Request 0x50 (same index 4, different tag), then 0x12 -> both requests miss and refill; `miss_cnt` increments by 2; data returned is correct for each address.
4. Invalidate. Pulse `inv` in the middle of refilling 0x20 -> 0x20 is still delivered; a following request for 0x20 misses; `hit_cnt` is unchanged.
5. Reset mid-refill. Deassert `rst_n` after the 2nd `mem_rvalid` -> `mem_req`=0 immediately; no `cpu_drdy`; counters are 0; a subsequent request for the same address misses.
6. Latency variation. Use memory latency 1 (combinational) and 5 on the same address -> identical returned data; miss-to-`cpu_drdy` of 6 and 22 cycles respectively.
